// File: rtl/lfsr_pattern_gen.sv
// lfsr_pattern_gen: Fibonacci-style LFSR pattern source with a valid/ready
// output, a run counter and an optional MISR that compacts response words.
// Optional feature macro: LFSR_MISR_EN (signature compaction). When it is not
// defined, signature is tied to 0 and resp_data/resp_valid are unused.
module lfsr_pattern_gen #(
    parameter int               WIDTH    = 12,
    parameter logic [WIDTH-1:0] TAPS     = 12'h829,
    parameter int               CNT_W    = 16,
    parameter logic [WIDTH-1:0] SEED_RST = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] seed,
    input  logic             seed_load,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_patterns,
    output logic [WIDTH-1:0] pat_data,
    output logic             pat_valid,
    input  logic             pat_ready,
    output logic             busy,
    output logic             done,
    input  logic [WIDTH-1:0] resp_data,
    input  logic             resp_valid,
    output logic [WIDTH-1:0] signature
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             hs;
    logic             start_ok;

    // A start is only honoured while idle; it also clears the MISR.
    assign start_ok = (state_q == IDLE) && start;
    assign hs       = pat_valid && pat_ready;
    assign pat_data = lfsr_q;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; abort wins over the final handshake so it never yields done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (num_patterns == '0) ? DONE : RUN;
            RUN: begin
                if (abort)                           state_d = IDLE;
                else if (hs && cnt_q == CNT_W'(1))   state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode; depends on the state register only, never on pat_ready.
    always_comb begin
        pat_valid = (state_q == RUN);
        busy      = (state_q == RUN) || (state_q == DONE);
        done      = (state_q == DONE);
    end

    // LFSR: seed load in idle (zero seed would lock up, so it becomes 1),
    // step on every accepted pattern, otherwise hold across runs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= SEED_RST;
        end else if (state_q == IDLE && seed_load) begin
            lfsr_q <= (seed == '0) ? WIDTH'(1) : seed;
        end else if (hs) begin
            lfsr_q <= {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
        end
    end

    // Remaining-pattern counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)       cnt_q <= '0;
        else if (start_ok) cnt_q <= num_patterns;
        else if (hs)       cnt_q <= cnt_q - CNT_W'(1);
    end

`ifdef LFSR_MISR_EN
    logic [WIDTH-1:0] sig_q;

    // MISR: cleared by an accepted start, otherwise folds in every valid response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)         sig_q <= '0;
        else if (start_ok)   sig_q <= '0;
        else if (resp_valid) sig_q <= {sig_q[WIDTH-2:0], ^(sig_q & TAPS)} ^ resp_data;
    end

    assign signature = sig_q;
`else
    logic unused_resp;
    assign unused_resp = ^{resp_valid, resp_data};
    assign signature   = '0;
`endif

endmodule

// File: tb/tb_lfsr_pattern_gen.sv
// Directed bench for lfsr_pattern_gen (default parameters, WIDTH=12).
module tb_lfsr_pattern_gen;

    logic        clk = 1'b0;
    logic        resetn;
    logic [11:0] seed;
    logic        seed_load;
    logic        start;
    logic        abort;
    logic [15:0] num_patterns;
    logic [11:0] pat_data;
    logic        pat_valid;
    logic        pat_ready;
    logic        busy;
    logic        done;
    logic [11:0] resp_data;
    logic        resp_valid;
    logic [11:0] signature;

    int checks   = 0;
    int failures = 0;

    lfsr_pattern_gen dut (
        .clk          (clk),
        .resetn       (resetn),
        .seed         (seed),
        .seed_load    (seed_load),
        .start        (start),
        .abort        (abort),
        .num_patterns (num_patterns),
        .pat_data     (pat_data),
        .pat_valid    (pat_valid),
        .pat_ready    (pat_ready),
        .busy         (busy),
        .done         (done),
        .resp_data    (resp_data),
        .resp_valid   (resp_valid),
        .signature    (signature)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] nxt(input logic [11:0] s);
        return {s[10:0], ^(s & 12'h829)};
    endfunction

    initial begin
        logic [11:0] exps [7] = '{12'h001, 12'h003, 12'h003, 12'h003, 12'h007, 12'h00F, 12'h01E};
        logic        rdys [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [11:0] seq5 [5] = '{12'h001, 12'h003, 12'h007, 12'h00F, 12'h01E};
        logic [11:0] exp_pat;
        logic [11:0] exp_sig;
        int          hs_cnt;
        int          mism;

        resetn = 1'b0; seed = '0; seed_load = 1'b0; start = 1'b0; abort = 1'b0;
        num_patterns = '0; pat_ready = 1'b0; resp_data = '0; resp_valid = 1'b0;
        tick(); tick();
        chk("rst_valid", pat_valid, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_lfsr",  pat_data, 12'h001);
        chk("rst_sig",   signature, 0);
        resetn = 1'b1;
        tick();

        // Basic 5-pattern run.
        seed = 12'h001; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        chk("seed_ld", pat_data, 12'h001);
        chk("idle_busy", busy, 0);
        start = 1'b1; num_patterns = 16'd5; pat_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("run5_valid", pat_valid, 1);
            chk("run5_data", pat_data, seq5[i]);
            chk("run5_nodone", done, 0);
            tick();
        end
        chk("run5_done", done, 1);
        chk("run5_done_busy", busy, 1);
        chk("run5_done_novalid", pat_valid, 0);
        tick();
        chk("run5_done_once", done, 0);
        chk("run5_idle_busy", busy, 0);
        chk("run5_lfsr_kept", pat_data, 12'h03D);

        // Zero seed is replaced by 1.
        seed = 12'h000; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        chk("zero_seed", pat_data, 12'h001);
        start = 1'b1; num_patterns = 16'd1;
        tick();
        start = 1'b0;
        chk("zero_seed_first", pat_data, 12'h001);
        chk("zero_seed_valid", pat_valid, 1);
        tick();
        chk("zero_seed_done", done, 1);
        tick();

        // Stalls: seed_load together with start, then ready 1,0,0,1,1,1,1.
        seed = 12'h001; seed_load = 1'b1; start = 1'b1; num_patterns = 16'd5;
        tick();
        seed_load = 1'b0; start = 1'b0;
        hs_cnt = 0;
        for (int c = 0; c < 7; c++) begin
            chk("stall_data", pat_data, exps[c]);
            chk("stall_nodone", done, 0);
            pat_ready = rdys[c];
            if (pat_valid && rdys[c]) hs_cnt++;
            tick();
        end
        chk("stall_hs", hs_cnt, 5);
        chk("stall_done", done, 1);
        tick();
        pat_ready = 1'b1;

        // Zero-length run.
        start = 1'b1; num_patterns = 16'd0;
        tick();
        start = 1'b0;
        chk("zero_n_valid", pat_valid, 0);
        chk("zero_n_done", done, 1);
        chk("zero_n_busy", busy, 1);
        chk("zero_n_lfsr", pat_data, 12'h03D);
        tick();
        chk("zero_n_idle_done", done, 0);
        chk("zero_n_idle_valid", pat_valid, 0);

        // Abort after two handshakes; start/seed_load during RUN are ignored.
        seed = 12'h001; seed_load = 1'b1; start = 1'b1; num_patterns = 16'd5;
        tick();
        seed_load = 1'b0; start = 1'b0;
        chk("ab_p0", pat_data, 12'h001);
        seed = 12'hABC; seed_load = 1'b1; start = 1'b1; num_patterns = 16'd7;
        tick();
        seed_load = 1'b0; start = 1'b0;
        chk("ab_p1_ignored", pat_data, 12'h003);
        tick();
        chk("ab_p2", pat_data, 12'h007);
        pat_ready = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_idle_busy", busy, 0);
        chk("ab_nodone", done, 0);
        chk("ab_hold", pat_data, 12'h007);
        tick();
        chk("ab_nodone2", done, 0);
        start = 1'b1; num_patterns = 16'd1; pat_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("ab_next", pat_data, 12'h007);
        tick();
        chk("ab_next_done", done, 1);
        tick();

        // Abort coincident with a handshake still steps the LFSR.
        start = 1'b1; num_patterns = 16'd3;
        tick();
        start = 1'b0;
        chk("abhs_p0", pat_data, 12'h00F);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abhs_step", pat_data, 12'h01E);
        chk("abhs_idle", busy, 0);
        chk("abhs_nodone", done, 0);
        tick();
        chk("abhs_nodone2", done, 0);

        // Reset in the middle of a run.
        start = 1'b1; num_patterns = 16'd10;
        tick();
        start = 1'b0;
        tick();
        resetn = 1'b0;
        #2;
        chk("mrst_busy", busy, 0);
        chk("mrst_valid", pat_valid, 0);
        chk("mrst_lfsr", pat_data, 12'h001);
        resetn = 1'b1;
        tick();
        chk("mrst_idle", busy, 0);
        chk("mrst_nodone", done, 0);

        // Full period with response compaction.
        seed = 12'h001; seed_load = 1'b1; start = 1'b1; num_patterns = 16'd4095;
        tick();
        seed_load = 1'b0; start = 1'b0;
        exp_pat = 12'h001;
        exp_sig = '0;
        mism = 0;
        for (int i = 0; i < 4095; i++) begin
            if (pat_data !== exp_pat || pat_valid !== 1'b1 || (i > 0 && pat_data == 12'h001)) mism++;
            resp_data = exp_pat; resp_valid = 1'b1;
            exp_sig = nxt(exp_sig) ^ exp_pat;
            exp_pat = nxt(exp_pat);
            tick();
        end
        resp_valid = 1'b0;
        chk("period_seq", mism, 0);
        chk("period_wrap", pat_data, 12'h001);
        chk("period_done", done, 1);
`ifdef LFSR_MISR_EN
        chk("misr_sig", signature, exp_sig);
`else
        chk("misr_off", signature, 0);
`endif
        tick();
        chk("period_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
